// File: rtl/mem_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for mem_arbiter.
// The arbiter connects through the master modport; the requesters and SRAM model use slave.
interface mem_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            lock_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [BE_WIDTH-1:0]           mem_be_o;
    logic [DATA_WIDTH-1:0]         mem_wdata_o;
    logic [DATA_WIDTH-1:0]         mem_rdata_i;

    modport master (
        input  req_i, we_i, addr_i, be_i, wdata_i, lock_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        output req_i, we_i, addr_i, be_i, wdata_i, lock_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port SRAM among NUM_REQ requesters.
// Optional grant locking is compiled in when MEM_ARBITER_LOCK_EN is defined.
module mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.master bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CAND_W   = RR_W + 1;
    localparam int unsigned CNT_W    = 8;

    logic [RR_W-1:0]       r_rr_q;
    logic [RR_W-1:0]       w_rr_d;
    logic [NUM_REQ-1:0]    r_rvalid_q;
    logic [NUM_REQ-1:0]    w_rvalid_d;
    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_any_gnt;
    logic [RR_W-1:0]       w_gnt_idx;
    logic [CAND_W-1:0]     w_cand;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [BE_WIDTH-1:0]   w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

`ifdef MEM_ARBITER_LOCK_EN
    logic             r_own_vld_q;
    logic             w_own_vld_d;
    logic [RR_W-1:0]  r_own_q;
    logic [RR_W-1:0]  w_own_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_excl_vld_q;
    logic             w_excl_vld_d;
    logic [RR_W-1:0]  r_excl_q;
    logic [RR_W-1:0]  w_excl_d;
    logic             w_own_hit;

    // A requester released by LOCK_MAX sits out exactly one cycle.
    assign w_own_hit = r_own_vld_q && bus.req_i[r_own_q];
    assign w_elig    = bus.req_i & ~(r_excl_vld_q ? (NUM_REQ'(1) << r_excl_q) : '0);
`else
    logic w_unused_lock;
    assign w_unused_lock = ^bus.lock_i;
    assign w_elig        = bus.req_i;
`endif

    // First eligible index at or after the pointer, wrapping; a live owner overrides.
    always_comb begin
        w_any_gnt = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = CAND_W'(r_rr_q) + CAND_W'(i);
            if (w_cand >= CAND_W'(NUM_REQ)) begin
                w_cand = w_cand - CAND_W'(NUM_REQ);
            end
            if (!w_any_gnt && w_elig[w_cand[RR_W-1:0]]) begin
                w_any_gnt = 1'b1;
                w_gnt_idx = w_cand[RR_W-1:0];
            end
        end
`ifdef MEM_ARBITER_LOCK_EN
        if (w_own_hit) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = r_own_q;
        end
`endif
        w_any_gnt = w_any_gnt & rst_ni;
        w_gnt     = w_any_gnt ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    end

    // Route the granted requester's payload to the SRAM; idle bus is all zero.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_be    = '0;
        w_mem_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_mem_we    = bus.we_i[k];
                w_mem_addr  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_mem_be    = bus.be_i[k*BE_WIDTH +: BE_WIDTH];
                w_mem_wdata = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_rr_d     = r_rr_q;
        w_rvalid_d = w_gnt & ~bus.we_i;
        if (w_any_gnt) begin
            w_rr_d = (w_gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + RR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_q     <= '0;
            r_rvalid_q <= '0;
        end else begin
            r_rr_q     <= w_rr_d;
            r_rvalid_q <= w_rvalid_d;
        end
    end

`ifdef MEM_ARBITER_LOCK_EN
    // Ownership tracking: acquire on a locked grant, drop on unlock, idle request or LOCK_MAX.
    always_comb begin
        w_own_vld_d  = r_own_vld_q;
        w_own_d      = r_own_q;
        w_cnt_d      = r_cnt_q;
        w_excl_vld_d = 1'b0;
        w_excl_d     = r_excl_q;
        w_cnt_inc    = CNT_W'(1);
        if (r_own_vld_q && !bus.req_i[r_own_q]) begin
            w_own_vld_d = 1'b0;
            w_cnt_d     = '0;
        end
        if (w_any_gnt) begin
            if (w_own_hit) begin
                w_cnt_inc = r_cnt_q + CNT_W'(1);
            end
            if (!bus.lock_i[w_gnt_idx]) begin
                w_own_vld_d = 1'b0;
                w_cnt_d     = '0;
            end else if (w_cnt_inc >= CNT_W'(LOCK_MAX)) begin
                w_own_vld_d  = 1'b0;
                w_cnt_d      = '0;
                w_excl_vld_d = 1'b1;
                w_excl_d     = w_gnt_idx;
            end else begin
                w_own_vld_d = 1'b1;
                w_own_d     = w_gnt_idx;
                w_cnt_d     = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_own_vld_q  <= 1'b0;
            r_own_q      <= '0;
            r_cnt_q      <= '0;
            r_excl_vld_q <= 1'b0;
            r_excl_q     <= '0;
        end else begin
            r_own_vld_q  <= w_own_vld_d;
            r_own_q      <= w_own_d;
            r_cnt_q      <= w_cnt_d;
            r_excl_vld_q <= w_excl_vld_d;
            r_excl_q     <= w_excl_d;
        end
    end
`endif

    assign bus.gnt_o       = w_gnt;
    assign bus.rvalid_o    = r_rvalid_q;
    assign bus.rdata_o     = bus.mem_rdata_i;
    assign bus.mem_req_o   = |w_gnt;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_be_o    = w_mem_be;
    assign bus.mem_wdata_o = w_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;
    localparam int unsigned NA   = 2;
    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned LMAX = 4;
    localparam int unsigned NB   = 4;
    localparam int unsigned AWB  = 16;
    localparam int unsigned DWB  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    mem_arbiter_if #(.NUM_REQ(NB), .ADDR_WIDTH(AWB), .DATA_WIDTH(DWB)) ifb ();

    mem_arbiter #(.NUM_REQ(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LMAX)) u_dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifa)
    );

    mem_arbiter #(.NUM_REQ(NB), .ADDR_WIDTH(AWB), .DATA_WIDTH(DWB), .LOCK_MAX(16)) u_dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int idx);
        return 64'h0123_4567_89AB_CDEF ^ {32'(idx), 32'(idx * 7)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM behaviour seen by requester A: writes land at the edge, reads return one cycle later.
    logic [63:0] env_mem [32];
    logic        env_ready = 1'b0;
    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= init_word(i);
            env_ready <= 1'b1;
        end else if (ifa.mem_req_o) begin
            if (ifa.mem_we_o) begin
                env_mem[ifa.mem_addr_o[7:3]] <= merge(env_mem[ifa.mem_addr_o[7:3]],
                                                      ifa.mem_wdata_o, ifa.mem_be_o);
            end else begin
                ifa.mem_rdata_i <= env_mem[ifa.mem_addr_o[7:3]];
            end
        end
    end
    assign ifb.mem_rdata_i = '0;

    // Reference model state: pointer, lock owner, grant count, excluded index, pending read.
    int          m_rr;
    int          m_owner;
    int          m_cnt;
    int          m_excl;
    int          m_rv;
    logic [63:0] m_rv_data;
    logic [63:0] sh_mem [32];

    task automatic model_reset();
        m_rr = 0; m_owner = -1; m_cnt = 0; m_excl = -1; m_rv = -1; m_rv_data = '0;
    endtask

    function automatic int model_pick();
        int k;
`ifdef MEM_ARBITER_LOCK_EN
        if (m_owner >= 0 && ifa.req_i[m_owner]) return m_owner;
`endif
        for (int i = 0; i < int'(NA); i++) begin
            k = (m_rr + i) % int'(NA);
            if (ifa.req_i[k] && k != m_excl) return k;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        logic [63:0] a;
`ifdef MEM_ARBITER_LOCK_EN
        int prev_owner;
        int cnt;
        prev_owner = m_owner;
`endif
        m_rv = -1;
        if (g >= 0) begin
            a = ifa.addr_i[g*64 +: 64];
            if (ifa.we_i[g]) begin
                sh_mem[a[7:3]] = merge(sh_mem[a[7:3]], ifa.wdata_i[g*64 +: 64], ifa.be_i[g*8 +: 8]);
            end else begin
                m_rv      = g;
                m_rv_data = sh_mem[a[7:3]];
            end
            m_rr = (g + 1) % int'(NA);
        end
`ifdef MEM_ARBITER_LOCK_EN
        m_excl = -1;
        if (m_owner >= 0 && !ifa.req_i[m_owner]) begin
            m_owner = -1; m_cnt = 0;
        end
        if (g >= 0) begin
            cnt = (g == prev_owner) ? m_cnt + 1 : 1;
            if (!ifa.lock_i[g]) begin
                m_owner = -1; m_cnt = 0;
            end else if (cnt >= int'(LMAX)) begin
                m_owner = -1; m_cnt = 0; m_excl = g;
            end else begin
                m_owner = g; m_cnt = cnt;
            end
        end
`endif
    endtask

    logic [1:0]  last_gnt;
    logic [1:0]  last_rv;
    logic [63:0] last_rdata;
    int          last_g;

    // One cycle on DUT A: compare all outputs against the model, then advance it.
    task automatic step_a();
        int         g;
        logic [1:0] eg;
        logic [1:0] erv;
        @(negedge clk);
        g   = model_pick();
        eg  = '0;
        erv = '0;
        if (g >= 0) eg[g] = 1'b1;
        if (m_rv >= 0) erv[m_rv] = 1'b1;
        last_gnt = ifa.gnt_o; last_rv = ifa.rvalid_o; last_rdata = ifa.rdata_o; last_g = g;
        chk("gnt", ifa.gnt_o, eg);
        chk("mem_req", ifa.mem_req_o, (g >= 0));
        if (g >= 0) begin
            chk("mem_we", ifa.mem_we_o, ifa.we_i[g]);
            chk("mem_addr", ifa.mem_addr_o, ifa.addr_i[g*64 +: 64]);
            chk("mem_be", ifa.mem_be_o, ifa.be_i[g*8 +: 8]);
            chk("mem_wdata", ifa.mem_wdata_o, ifa.wdata_i[g*64 +: 64]);
        end else begin
            chk("mem_addr_idle", ifa.mem_addr_o, 64'h0);
            chk("mem_wdata_idle", {ifa.mem_wdata_o[55:0], ifa.mem_be_o}, 64'h0);
        end
        chk("rvalid", ifa.rvalid_o, erv);
        if (m_rv >= 0) chk("rdata", ifa.rdata_o, m_rv_data);
        model_update(g);
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  last_gnt_b;
    logic [15:0] last_addr_b;

    task automatic step_b();
        @(negedge clk);
        last_gnt_b  = ifb.gnt_o;
        last_addr_b = ifb.mem_addr_o;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_lock [7];
    logic [1:0] pend;

    initial begin
        rst_n       = 1'b0;
        ifa.req_i   = '0; ifa.we_i = '0; ifa.addr_i = '0; ifa.be_i = '0;
        ifa.wdata_i = '0; ifa.lock_i = '0;
        ifb.req_i   = '0; ifb.we_i = '0; ifb.addr_i = '0; ifb.be_i = '0;
        ifb.wdata_i = '0; ifb.lock_i = '0;
        for (int i = 0; i < 32; i++) sh_mem[i] = init_word(i);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt_a", ifa.gnt_o, 2'b00);
        chk("rst_rvalid_a", ifa.rvalid_o, 2'b00);
        chk("rst_mem_req_a", ifa.mem_req_o, 1'b0);
        chk("rst_gnt_b", ifb.gnt_o, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four requesters: park the pointer at 2, then 1010 grants 3,1,3.
        ifb.addr_i = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
        ifb.req_i  = 4'b0010;
        step_b(); chk("b_first", last_gnt_b, 4'b0010);
        ifb.req_i  = 4'b1010;
        step_b(); chk("b_g3", last_gnt_b, 4'b1000); chk("b_addr3", last_addr_b, 16'h0333);
        step_b(); chk("b_g1", last_gnt_b, 4'b0010); chk("b_addr1", last_addr_b, 16'h0111);
        step_b(); chk("b_g3b", last_gnt_b, 4'b1000);
        ifb.req_i  = '0;

        // Both reading: strict alternation starting at requester 0.
        ifa.req_i  = 2'b11; ifa.we_i = 2'b00; ifa.be_i = 16'hFFFF;
        ifa.addr_i = {64'h88, 64'h80};
        for (int i = 0; i < 4; i++) begin
            step_a();
            chk("rr_seq", last_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Write through requester 0, read back through requester 1.
        ifa.req_i = 2'b01; ifa.we_i = 2'b01;
        ifa.addr_i[63:0] = 64'h40; ifa.wdata_i[63:0] = 64'hDEAD_BEEF;
        step_a(); chk("wr_gnt", last_gnt, 2'b01);
        ifa.req_i = 2'b10; ifa.we_i = 2'b00; ifa.addr_i[127:64] = 64'h40;
        step_a(); chk("rd_gnt", last_gnt, 2'b10);
        ifa.req_i = 2'b00;
        step_a(); chk("wr_rd_rv", last_rv, 2'b10); chk("wr_rd_data", last_rdata, 64'hDEAD_BEEF);

        // Reset right after a read grant drops the pending response.
        ifa.req_i = 2'b01;
        step_a(); chk("pre_rst_gnt", last_gnt, 2'b01);
        ifa.req_i = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_rv", ifa.rvalid_o, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rv", ifa.rvalid_o, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Requester 0 holds lock with both requesting.
`ifdef MEM_ARBITER_LOCK_EN
        exp_lock[0] = 2'b01; exp_lock[1] = 2'b01; exp_lock[2] = 2'b01; exp_lock[3] = 2'b01;
        exp_lock[4] = 2'b10; exp_lock[5] = 2'b01; exp_lock[6] = 2'b01;
`else
        exp_lock[0] = 2'b01; exp_lock[1] = 2'b10; exp_lock[2] = 2'b01; exp_lock[3] = 2'b10;
        exp_lock[4] = 2'b01; exp_lock[5] = 2'b10; exp_lock[6] = 2'b01;
`endif
        ifa.req_i = 2'b11; ifa.we_i = 2'b00; ifa.lock_i = 2'b01;
        ifa.addr_i = {64'h88, 64'h80};
        for (int i = 0; i < 7; i++) begin
            step_a();
            chk("lock_seq", last_gnt, exp_lock[i]);
        end
        ifa.lock_i = 2'b00;

        // Randomized traffic; each requester holds its request until granted.
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < int'(NA); k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    pend[k]                = 1'b1;
                    ifa.we_i[k]            = 1'($urandom_range(0, 1));
                    ifa.addr_i[k*64 +: 64] = 64'($urandom_range(0, 15) * 8);
                    ifa.be_i[k*8 +: 8]     = 8'($urandom);
                    ifa.wdata_i[k*64 +: 64] = {32'($urandom), 32'($urandom)};
                end
                ifa.lock_i[k] = ($urandom_range(0, 2) != 0);
            end
            ifa.req_i = pend;
            step_a();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        ifa.req_i = '0;
        step_a();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
